demux1x2: RTL

DEMUX1X2 -- requirements
Module: demux1x2

---
 rtl/demux1x2.sv | 64 ++++++
 1 files changed

// File: rtl/demux1x2.sv
// demux1x2: steers each input word into one of two independent output FIFOs chosen by sel.
module demux1x2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] full, empty, push, pop, rdy;
  logic [WIDTH-1:0] head [2];
  logic [15:0] cnt [2];
  assign rdy = {out1_ready, out0_ready};
  assign in_ready = !reset && !full[sel];
  for (genvar q = 0; q < 2; q++) begin : g_q
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q, wr_d, rd_d;
    logic [15:0] cnt_q, cnt_d;
    // extra pointer MSB separates full from empty when the index bits match
    assign empty[q] = wr_q == rd_q;
    assign full[q] = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push[q] = in_valid && in_ready && (sel == 1'(q));
    assign pop[q] = !empty[q] && rdy[q];
    assign head[q] = empty[q] ? '0 : mem_q[rd_q[AW-1:0]];
    assign cnt[q] = cnt_q;
    always_comb begin
      wr_d = push[q] ? wr_q + 1'b1 : wr_q;
      rd_d = pop[q] ? rd_q + 1'b1 : rd_q;
      cnt_d = (pop[q] && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_q <= '0;
        rd_q <= '0;
        cnt_q <= '0;
      end else begin
        wr_q <= wr_d;
        rd_q <= rd_d;
        cnt_q <= cnt_d;
      end
    end
    always_ff @(posedge clk) begin
      if (push[q]) mem_q[wr_q[AW-1:0]] <= in_data;
    end
  end
  assign out0_valid = !empty[0];
  assign out1_valid = !empty[1];
  assign out0_data = head[0];
  assign out1_data = head[1];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
endmodule
